// File: rtl/symbol_transmitter_pkg.sv
// Shared definitions for the ZERO/ONE symbol link: symbol codes, transmitter
// state encoding and the per-symbol wire phase table. The receiver side
// imports the same symbol codes.
package symbol_transmitter_pkg;

    // Symbol codes carried on sym_in; 6 and 7 are illegal.
    localparam logic [2:0] SYM_ZERO = 3'd0;
    localparam logic [2:0] SYM_ONE  = 3'd1;
    localparam logic [2:0] SYM_FS   = 3'd2;
    localparam logic [2:0] SYM_X0   = 3'd3;
    localparam logic [2:0] SYM_FE   = 3'd4;
    localparam logic [2:0] SYM_FD   = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_REL = 2'd3
    } tx_state_e;

    // Phase table, each entry {ZERO_OUT, ONE_OUT}; phase 0 sits in the MSBs.
    // Single-phase symbols pad unused slots with 00.
    localparam logic [5:0] SEQ_ZERO = {2'b10, 2'b00, 2'b00};
    localparam logic [5:0] SEQ_ONE  = {2'b01, 2'b00, 2'b00};
    localparam logic [5:0] SEQ_FS   = {2'b10, 2'b11, 2'b10};
    localparam logic [5:0] SEQ_X0   = {2'b10, 2'b11, 2'b01};
    localparam logic [5:0] SEQ_FE   = {2'b01, 2'b11, 2'b10};
    localparam logic [5:0] SEQ_FD   = {2'b01, 2'b11, 2'b01};

    function automatic logic sym_is_legal(input logic [2:0] sym);
        return sym <= SYM_FD;
    endfunction

    function automatic logic [5:0] phase_seq(input logic [2:0] sym);
        case (sym)
            SYM_ZERO: return SEQ_ZERO;
            SYM_ONE:  return SEQ_ONE;
            SYM_FS:   return SEQ_FS;
            SYM_X0:   return SEQ_X0;
            SYM_FE:   return SEQ_FE;
            SYM_FD:   return SEQ_FD;
            default:  return 6'b0;
        endcase
    endfunction

    // Number of phases minus one, so it compares directly with a phase index.
    function automatic logic [1:0] last_phase(input logic [2:0] sym);
        return (sym == SYM_ZERO || sym == SYM_ONE) ? 2'd0 : 2'd2;
    endfunction

    function automatic logic [1:0] phase_wires(input logic [2:0] sym,
                                               input logic [1:0] idx);
        logic [5:0] seq;
        seq = phase_seq(sym);
        case (idx)
            2'd0:    return seq[5:4];
            2'd1:    return seq[3:2];
            default: return seq[1:0];
        endcase
    endfunction

endpackage

// File: rtl/symbol_transmitter_ack_sync.sv
// ack_sync: two-flop synchroniser for an asynchronous handshake line, with
// synchronous active-high reset. Also used by the receiver on its *_IN lines.
module ack_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two flops in series give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let both stages sample the old values
        // on the same edge, which is what makes this a two-stage shift.
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/symbol_transmitter.sv
// symbol_transmitter: transmit end of the two-wire ZERO/ONE symbol link.
// Takes one symbol per valid/ready transfer, plays its phase sequence on
// ZERO_OUT/ONE_OUT, then runs a four-phase handshake on ACK.
// Optional macro TX_TIMEOUT_EN adds an ACK wait limit of TIMEOUT_CYC cycles.
module symbol_transmitter
    import symbol_transmitter_pkg::*;
#(
    parameter int unsigned PHASE_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic       ACK,
    output logic       ZERO_OUT,
    output logic       ONE_OUT,
    output logic       busy,
    output logic       sym_done,
    output logic       err_illegal,
    output logic       timeout
);

    localparam logic [7:0] HOLD_RELOAD = 8'(PHASE_CYC - 1);

    tx_state_e  state_q, state_d;
    logic [2:0] sym_q, sym_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] wires_q, wires_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       timeout_d;
    logic       ack_s;
    logic       accept;

    ack_sync u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (ACK),
        .q_o   (ack_s)
    );

    assign sym_ready = (state_q == IDLE) && !ack_s && !reset;
    assign accept    = sym_valid && sym_ready;

`ifdef TX_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q;
    logic        tmo_hit;

    assign tmo_hit = ((state_q == WAIT_ACK) || (state_q == WAIT_REL)) &&
                     (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign timeout            = 1'b0;
`endif

    // Next-state logic: phase sequencing, handshake waits, pulse generation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        sym_d     = sym_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        wires_d   = wires_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sym_is_legal(sym_in)) begin
                        state_d = DRIVE;
                        sym_d   = sym_in;
                        phase_d = 2'd0;
                        hold_d  = HOLD_RELOAD;
                        wires_d = phase_wires(sym_in, 2'd0);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end else if (phase_q == last_phase(sym_q)) begin
                    wires_d = 2'b00;
                    state_d = WAIT_ACK;
                end else begin
                    phase_d = phase_q + 2'd1;
                    hold_d  = HOLD_RELOAD;
                    wires_d = phase_wires(sym_q, phase_q + 2'd1);
                end
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef TX_TIMEOUT_EN
        // A handshake completing on the limit edge still counts as success.
        if (tmo_hit && !done_d) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
        end
`endif
    end

`ifdef TX_TIMEOUT_EN
    // Wait counter: cleared on entry to WAIT_ACK, runs through WAIT_REL.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == DRIVE && state_d == WAIT_ACK) begin
            tmo_cnt_d = 16'd0;
        end else if (state_q == WAIT_ACK || state_q == WAIT_REL) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_timeout_d;

    assign unused_timeout_d = timeout_d;
`endif

    // Main state registers; reset forces idle with both wires low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sym_q   <= SYM_ZERO;
            phase_q <= 2'd0;
            hold_q  <= 8'd0;
            wires_q <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            wires_q <= wires_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ZERO_OUT    = wires_q[1];
    assign ONE_OUT     = wires_q[0];
    assign busy        = (state_q != IDLE);
    assign sym_done    = done_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_symbol_transmitter.sv
// Directed bench for symbol_transmitter with PHASE_CYC=4, TIMEOUT_CYC=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_symbol_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       ACK;
    logic       ZERO_OUT;
    logic       ONE_OUT;
    logic       busy;
    logic       sym_done;
    logic       err_illegal;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    symbol_transmitter #(
        .PHASE_CYC   (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sym_in      (sym_in),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .ACK         (ACK),
        .ZERO_OUT    (ZERO_OUT),
        .ONE_OUT     (ONE_OUT),
        .busy        (busy),
        .sym_done    (sym_done),
        .err_illegal (err_illegal),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sym_done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] wires();
        return {ZERO_OUT, ONE_OUT};
    endfunction

    // Present one symbol for a single cycle; returns at the first sample
    // after the accepting edge.
    task automatic send(input logic [2:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    // Send a symbol and check every wire cycle plus the final 00.
    task automatic play(input string tag, input logic [2:0] s,
                        input logic [5:0] seq, input int nph);
        logic [1:0] exp;
        check({tag, " ready"}, {31'b0, sym_ready}, 1);
        send(s);
        for (int i = 0; i < nph * 4; i++) begin
            case (i / 4)
                0:       exp = seq[5:4];
                1:       exp = seq[3:2];
                default: exp = seq[1:0];
            endcase
            check($sformatf("%s wires c%0d", tag, i), {30'b0, wires()}, {30'b0, exp});
            check($sformatf("%s busy c%0d", tag, i), {31'b0, busy}, 1);
            @(negedge clk);
        end
        check({tag, " end 00"}, {30'b0, wires()}, 0);
        check({tag, " end busy"}, {31'b0, busy}, 1);
    endtask

    // Four-phase ACK handshake. sym_done is expected on the third sample
    // after ACK falls: two synchroniser edges then the FSM edge. When
    // race_valid is set, sym_valid is raised just before that final edge
    // and must not be taken.
    task automatic handshake(input string tag, input int pre, input bit race_valid);
        repeat (pre) @(negedge clk);
        check({tag, " pre 00"}, {30'b0, wires()}, 0);
        ACK = 1'b1;
        repeat (5) @(negedge clk);
        check({tag, " ack 00"}, {30'b0, wires()}, 0);
        check({tag, " ack busy"}, {31'b0, busy}, 1);
        check({tag, " ack ready"}, {31'b0, sym_ready}, 0);
        ACK = 1'b0;
        @(negedge clk);
        check({tag, " done1"}, {31'b0, sym_done}, 0);
        @(negedge clk);
        check({tag, " done2"}, {31'b0, sym_done}, 0);
        check({tag, " rel ready"}, {31'b0, sym_ready}, 0);
        if (race_valid) begin
            sym_in    = 3'd0;
            sym_valid = 1'b1;
        end
        @(negedge clk);
        sym_valid = 1'b0;
        check({tag, " done3"}, {31'b0, sym_done}, 1);
        check({tag, " idle ready"}, {31'b0, sym_ready}, 1);
        check({tag, " idle busy"}, {31'b0, busy}, 0);
        check({tag, " idle 00"}, {30'b0, wires()}, 0);
        @(negedge clk);
        check({tag, " done4"}, {31'b0, sym_done}, 0);
        check({tag, " no accept"}, {31'b0, busy}, 0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        sym_in    = 3'd0;
        sym_valid = 1'b0;
        ACK       = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst ready", {31'b0, sym_ready}, 0);
        check("rst wires", {30'b0, wires()}, 0);
        check("rst busy", {31'b0, busy}, 0);
        check("rst pulses", {29'b0, sym_done, err_illegal, timeout}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post rst ready", {31'b0, sym_ready}, 1);

        // Single-phase ZERO with the long handshake.
        play("zero", 3'd0, {2'b10, 2'b00, 2'b00}, 1);
        handshake("zero hs", 9, 1'b0);

        // Three-phase symbols back to back; the last one races sym_valid
        // against the releasing edge.
        base = done_seen;
        play("fs", 3'd2, {2'b10, 2'b11, 2'b10}, 3);
        handshake("fs hs", 1, 1'b0);
        play("x0", 3'd3, {2'b10, 2'b11, 2'b01}, 3);
        handshake("x0 hs", 1, 1'b0);
        play("fe", 3'd4, {2'b01, 2'b11, 2'b10}, 3);
        handshake("fe hs", 1, 1'b0);
        play("fd", 3'd5, {2'b01, 2'b11, 2'b01}, 3);
        handshake("fd hs", 1, 1'b1);
        check("four dones", done_seen - base, 4);

        // Stale ACK held through reset blocks acceptance.
        ACK = 1'b1;
        do_reset(2);
        repeat (3) @(negedge clk);
        sym_in    = 3'd1;
        sym_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stale ready", {31'b0, sym_ready}, 0);
            check("stale wires", {30'b0, wires()}, 0);
            check("stale busy", {31'b0, busy}, 0);
        end
        ACK = 1'b0;
        @(negedge clk);
        check("stale rel1 ready", {31'b0, sym_ready}, 0);
        @(negedge clk);
        check("stale rel2 ready", {31'b0, sym_ready}, 1);
        @(negedge clk);
        sym_valid = 1'b0;
        check("stale accept busy", {31'b0, busy}, 1);
        check("stale accept wires", {30'b0, wires()}, 2'b01);
        repeat (3) @(negedge clk);
        check("stale one last", {30'b0, wires()}, 2'b01);
        @(negedge clk);
        check("stale one end", {30'b0, wires()}, 0);
        handshake("stale hs", 1, 1'b0);

        // Illegal codes.
        base = done_seen;
        for (int c = 6; c <= 7; c++) begin
            send(3'(c));
            check($sformatf("ill%0d err", c), {31'b0, err_illegal}, 1);
            check($sformatf("ill%0d busy", c), {31'b0, busy}, 0);
            check($sformatf("ill%0d wires", c), {30'b0, wires()}, 0);
            @(negedge clk);
            check($sformatf("ill%0d err end", c), {31'b0, err_illegal}, 0);
            check($sformatf("ill%0d ready", c), {31'b0, sym_ready}, 1);
        end
        check("ill no done", done_seen - base, 0);

        // Reset during the 11 phase of X0.
        base = done_seen;
        send(3'd3);
        repeat (5) @(negedge clk);
        check("mid x0 11", {30'b0, wires()}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst wires", {30'b0, wires()}, 0);
        check("mid rst busy", {31'b0, busy}, 0);
        check("mid rst ready", {31'b0, sym_ready}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid rst ready after", {31'b0, sym_ready}, 1);
        check("mid rst no done", done_seen - base, 0);

        // ACK never arrives.
        base = done_seen;
        send(3'd1);
        repeat (4) @(negedge clk);
        check("tmo wait 00", {30'b0, wires()}, 0);
`ifdef TX_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("tmo quiet %0d", i), {30'b0, timeout, busy}, 2'b01);
        end
        @(negedge clk);
        check("tmo pulse", {31'b0, timeout}, 1);
        check("tmo idle", {31'b0, busy}, 0);
        check("tmo ready", {31'b0, sym_ready}, 1);
        @(negedge clk);
        check("tmo pulse end", {31'b0, timeout}, 0);
        check("tmo no done", done_seen - base, 0);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout !== 1'b0 || busy !== 1'b1)
                check($sformatf("notmo wait %0d", i), {30'b0, timeout, busy}, 2'b01);
        end
        check("notmo still busy", {31'b0, busy}, 1);
        check("notmo timeout", {31'b0, timeout}, 0);
        handshake("notmo hs", 1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
